// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, functs, aluop,
// state and datapath-select encodings, plus an instruction-class helper.
package mc_ctrl_pkg;

    localparam int ALUOP_WIDTH = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD = 5'd0;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB = 5'd1;
    localparam logic [ALUOP_WIDTH-1:0] ALU_AND = 5'd2;
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR  = 5'd3;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLT = 5'd4;
    localparam logic [ALUOP_WIDTH-1:0] ALU_LUI = 5'd5;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;

    localparam logic [1:0] SRCB_BUS  = 2'd0;
    localparam logic [1:0] SRCB_SEXT = 2'd1;
    localparam logic [1:0] SRCB_ZEXT = 2'd2;
    localparam logic [1:0] SRCB_LUI  = 2'd3;

    typedef enum logic [2:0] {
        IC_ALU,
        IC_BEQ,
        IC_J,
        IC_LW,
        IC_SW,
        IC_BAD
    } iclass_t;

    function automatic iclass_t iclass(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDIU, OP_ORI, OP_LUI: return IC_ALU;
            OP_BEQ:                             return IC_BEQ;
            OP_J:                               return IC_J;
            OP_LW:                              return IC_LW;
            OP_SW:                              return IC_SW;
            default:                            return IC_BAD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle: IR fields, alu flag, memory
// handshakes and every control output of mc_ctrl.
interface mc_ctrl_if #(
    parameter int ALUOP_W = 5,
    parameter int STATE_W = 3
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               imem_ready;
    logic               dmem_ready;

    logic               imem_req;
    logic               dmem_req;
    logic               dmem_write;
    logic               ir_write;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic               mem_to_reg;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, funct, zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_write, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_b, aluop, illegal, state
    );

    modport slave (
        output op, funct, zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_write, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_b, aluop, illegal, state
    );

endinterface

// File: rtl/mc_alu_dec.sv
// Combinational instruction decode: (op, funct) -> aluop, alu_src_b and
// whether the instruction is part of the supported set.
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = ALUOP_WIDTH
) (
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    output logic [ALUOP_W-1:0] aluop,
    output logic [1:0]         alu_src_b,
    output logic               legal
);

    always_comb begin
        aluop     = ALUOP_W'(ALU_ADD);
        alu_src_b = SRCB_BUS;
        legal     = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: aluop = ALUOP_W'(ALU_ADD);
                    FN_SUBU: aluop = ALUOP_W'(ALU_SUB);
                    FN_AND:  aluop = ALUOP_W'(ALU_AND);
                    FN_OR:   aluop = ALUOP_W'(ALU_OR);
                    FN_SLT:  aluop = ALUOP_W'(ALU_SLT);
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDIU: alu_src_b = SRCB_SEXT;
            OP_ORI: begin
                aluop     = ALUOP_W'(ALU_OR);
                alu_src_b = SRCB_ZEXT;
            end
            OP_LUI: begin
                aluop     = ALUOP_W'(ALU_LUI);
                alu_src_b = SRCB_LUI;
            end
            OP_LW, OP_SW: alu_src_b = SRCB_SEXT;
            OP_BEQ:       aluop     = ALUOP_W'(ALU_SUB);
            OP_J:         legal     = 1'b1;
            default:      legal     = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with req/ready
// memory handshakes. Define MC_CTRL_PERF_EN to add retired/cycles counters.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = ALUOP_WIDTH,
    parameter int STATE_W = 3
) (
    input  logic        clock,
    input  logic        reset,
    mc_ctrl_if.master   bus
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] cycles
`endif
);

    logic [2:0]         st;
    logic [2:0]         st_nx;
    logic [5:0]         op_q;
    logic [5:0]         funct_q;
    logic [5:0]         dec_op;
    logic [5:0]         dec_funct;
    logic [ALUOP_W-1:0] dec_aluop;
    logic [1:0]         dec_src_b;
    logic               dec_legal;
    iclass_t            cls;

    logic       imem_req;
    logic       dmem_req;
    logic       dmem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       alu_en;

    always_ff @(posedge clock) begin
        if (!reset) begin
            st      <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            st <= st_nx;
            if (st == S_DECODE) begin
                op_q    <= bus.op;
                funct_q <= bus.funct;
            end
        end
    end

    // DECODE must classify the live IR fields since op_q/funct_q load on that edge.
    assign dec_op    = (st == S_DECODE) ? bus.op : op_q;
    assign dec_funct = (st == S_DECODE) ? bus.funct : funct_q;
    assign cls       = iclass(dec_op);

    mc_alu_dec #(
        .ALUOP_W(ALUOP_W)
    ) u_alu_dec (
        .op       (dec_op),
        .funct    (dec_funct),
        .aluop    (dec_aluop),
        .alu_src_b(dec_src_b),
        .legal    (dec_legal)
    );

    always_comb begin
        st_nx      = st;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_write = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        reg_write  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        alu_en     = 1'b0;
        case (st)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    st_nx    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    st_nx = S_TRAP;
                end else if (cls == IC_J) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                    st_nx    = S_FETCH;
                end else begin
                    st_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (cls == IC_BEQ) begin
                    if (bus.zero) begin
                        pc_write = 1'b1;
                        pc_src   = PC_BRANCH;
                    end
                    st_nx = S_FETCH;
                end else if (cls == IC_LW || cls == IC_SW) begin
                    st_nx = S_MEM;
                end else begin
                    st_nx = S_WB;
                end
            end
            // The datapath has no ALU result register, so the ALU keeps its
            // EXEC setting through MEM (address) and WB (result).
            S_MEM: begin
                alu_en     = 1'b1;
                dmem_req   = 1'b1;
                dmem_write = (cls == IC_SW);
                if (bus.dmem_ready) begin
                    st_nx = (cls == IC_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                alu_en     = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = (dec_op == OP_RTYPE) ? RD_RD : RD_RT;
                mem_to_reg = (cls == IC_LW);
                st_nx      = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
                st_nx   = S_TRAP;
            end
            default: st_nx = S_FETCH;
        endcase
    end

    // Every output is held at zero while reset is low, abandoning any instruction.
    assign bus.imem_req   = reset & imem_req;
    assign bus.dmem_req   = reset & dmem_req;
    assign bus.dmem_write = reset & dmem_write;
    assign bus.ir_write   = reset & ir_write;
    assign bus.pc_write   = reset & pc_write;
    assign bus.pc_src     = reset ? pc_src : '0;
    assign bus.reg_write  = reset & reg_write;
    assign bus.reg_dst    = reset ? reg_dst : '0;
    assign bus.mem_to_reg = reset & mem_to_reg;
    assign bus.alu_src_b  = (reset && alu_en) ? dec_src_b : '0;
    assign bus.aluop      = (reset && alu_en) ? dec_aluop : '0;
    assign bus.illegal    = reset & illegal;
    assign bus.state      = reset ? STATE_W'(st) : '0;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] retired_q;
    logic [31:0] cycles_q;
    logic        retire;

    assign retire = (st_nx == S_FETCH) &&
                    (st inside {S_DECODE, S_EXEC, S_MEM, S_WB});

    always_ff @(posedge clock) begin
        if (!reset) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign retired = reset ? retired_q : '0;
    assign cycles  = reset ? cycles_q : '0;
`endif

endmodule
